// File: rtl/mmio_port_responder_pkg.sv
// Shared definitions for the MMIO port responder: default window base and
// the word-offset register map inside the 16-byte window.
package mmio_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_1000;

  typedef enum logic [1:0] {
    OFS_PORT_OUT = 2'd0,
    OFS_PORT_IN  = 2'd1,
    OFS_EDGE     = 2'd2,
    OFS_COUNT    = 2'd3
  } reg_sel_e;

endpackage

// File: rtl/mmio_port_responder_if.sv
// MEM-stage data bus as seen by a memory-mapped target: address/data/strobes
// from the pipeline, combinational read data and window hit back.
interface mmio_port_responder_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;
  logic        Hit;

  modport master (
    output Address, WriteData, MemWrite, MemRead,
    input  ReadData, Hit
  );

  modport slave (
    input  Address, WriteData, MemWrite, MemRead,
    output ReadData, Hit
  );
endinterface

// File: rtl/mmio_port_responder_sync.sv
// Two-flop synchronizer with a history flop, giving a clean synchronized
// level and a one-cycle rising-edge pulse per input bit.
module input_synchronizer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] s1, s2, s3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sync = s2;
  assign rise = s2 & ~s3;

endmodule

// File: rtl/mmio_port_responder.sv
// Memory-mapped I/O target on the MEM-stage bus: output latch, synchronized
// input port with sticky rising-edge flags, and a loadable cycle counter.
module mmio_port_responder
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          IN_WIDTH  = 8
) (
  input  logic                clk,
  input  logic                reset,
  mmio_port_responder_if.slave bus,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         PortOut
);

  logic                hit;
  reg_sel_e            sel;
  logic                store;
  logic [IN_WIDTH-1:0] in_sync;
  logic [IN_WIDTH-1:0] in_rise;
  logic [IN_WIDTH-1:0] edge_flags;
  logic [IN_WIDTH-1:0] edge_clr;
  logic [31:0]         count_q;
  logic [31:0]         in_sync_ext;
  logic [31:0]         edge_ext;
  logic                unused_byte_lane;

  // Word access only: the byte-lane bits are deliberately ignored.
  assign unused_byte_lane = ^bus.Address[1:0];

  assign hit   = (bus.Address[31:4] == BASE_ADDR[31:4]);
  assign sel   = reg_sel_e'(bus.Address[3:2]);
  assign store = hit & bus.MemWrite;
  assign bus.Hit = hit;

  input_synchronizer #(.WIDTH(IN_WIDTH)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (PortIn),
    .sync     (in_sync),
    .rise     (in_rise)
  );

  assign edge_clr = (store && sel == OFS_EDGE) ? bus.WriteData[IN_WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PortOut    <= '0;
      edge_flags <= '0;
      count_q    <= '0;
    end else begin
      if (store && sel == OFS_PORT_OUT)
        PortOut <= bus.WriteData;
      // A rise arriving on the same edge as its W1C clear must not be lost.
      edge_flags <= (edge_flags & ~edge_clr) | in_rise;
      if (store && sel == OFS_COUNT)
        count_q <= bus.WriteData;
      else
        count_q <= count_q + 32'd1;
    end
  end

  always_comb begin
    in_sync_ext = '0;
    in_sync_ext[IN_WIDTH-1:0] = in_sync;
    edge_ext = '0;
    edge_ext[IN_WIDTH-1:0] = edge_flags;
  end

  always_comb begin
    bus.ReadData = '0;
    if (hit && bus.MemRead) begin
      case (sel)
        OFS_PORT_OUT: bus.ReadData = PortOut;
        OFS_PORT_IN:  bus.ReadData = in_sync_ext;
        OFS_EDGE:     bus.ReadData = edge_ext;
        OFS_COUNT:    bus.ReadData = count_q;
        default:      bus.ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed bench for mmio_port_responder: inputs change just after the
// falling edge, outputs are compared 1 time unit later.
module tb_mmio_port_responder;

  localparam logic [31:0] BASE = 32'h1001_1000;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] PortIn;
  logic [31:0] PortOut;
  int checks = 0;
  int failures = 0;

  mmio_port_responder_if bus ();

  mmio_port_responder #(.BASE_ADDR(BASE), .IN_WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .PortIn  (PortIn),
    .PortOut (PortOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] addr, input logic [31:0] wd,
                       input logic wr, input logic rd);
    bus.Address   = addr;
    bus.WriteData = wd;
    bus.MemWrite  = wr;
    bus.MemRead   = rd;
  endtask

  // Advance to the next falling edge (one rising edge has passed).
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    reset  = 1'b0;
    PortIn = 8'h00;
    drive(BASE, 32'h0, 1'b0, 1'b1);
    #3;
    check("reset_hit", 32'(bus.Hit), 32'h1);
    check("reset_rd_portout", bus.ReadData, 32'h0);
    check("reset_portout", PortOut, 32'h0);

    // Release reset; counter reads 0, then 1, 2, 3.
    next_cycle();
    reset = 1'b1;
    drive(BASE + 32'hC, 32'h0, 1'b0, 1'b1);
    #1 check("count_0", bus.ReadData, 32'h0);
    next_cycle(); #1 check("count_1", bus.ReadData, 32'h1);
    next_cycle(); #1 check("count_2", bus.ReadData, 32'h2);
    next_cycle(); #1 check("count_3", bus.ReadData, 32'h3);

    // Store with simultaneous load: pre-store value visible this cycle.
    next_cycle();
    drive(BASE, 32'hDEAD_BEEF, 1'b1, 1'b1);
    #1 check("rd_before_store", bus.ReadData, 32'h0);
    next_cycle();
    drive(BASE, 32'h0, 1'b0, 1'b1);
    #1 check("portout_store", PortOut, 32'hDEAD_BEEF);
    check("rd_portout", bus.ReadData, 32'hDEAD_BEEF);
    drive(BASE, 32'h0, 1'b0, 1'b0);
    #1 check("no_memread_zero", bus.ReadData, 32'h0);

    // Store just outside the window.
    next_cycle();
    drive(BASE + 32'h10, 32'h1234_5678, 1'b1, 1'b1);
    #1 check("miss_hit", 32'(bus.Hit), 32'h0);
    check("miss_rd", bus.ReadData, 32'h0);
    next_cycle();
    drive(BASE, 32'h0, 1'b0, 1'b0);
    #1 check("miss_portout", PortOut, 32'hDEAD_BEEF);

    // Store to read-only PORT_IN has no effect on the latch.
    next_cycle();
    drive(BASE + 32'h4, 32'h0000_00FF, 1'b1, 1'b0);
    next_cycle();
    drive(BASE + 32'h4, 32'h0, 1'b0, 1'b1);
    #1 check("ro_portin_rd", bus.ReadData, 32'h0);
    check("ro_portout", PortOut, 32'hDEAD_BEEF);

    // PortIn = 5 before edge k.
    next_cycle();
    PortIn = 8'h05;
    #1 check("portin_pre_k", bus.ReadData, 32'h0);
    next_cycle();                      // edge k: s1
    #1 check("portin_after_k", bus.ReadData, 32'h0);
    next_cycle();                      // edge k+1: s2
    #1 check("portin_after_k1", bus.ReadData, 32'h5);
    drive(BASE + 32'h8, 32'h0, 1'b0, 1'b1);
    #1 check("edge_after_k1", bus.ReadData, 32'h0);
    next_cycle();                      // edge k+2: flags set
    #1 check("edge_after_k2", bus.ReadData, 32'h5);

    // W1C clear of bit 0.
    drive(BASE + 32'h8, 32'h1, 1'b1, 1'b1);
    next_cycle();
    drive(BASE + 32'h8, 32'h0, 1'b0, 1'b1);
    #1 check("edge_w1c", bus.ReadData, 32'h4);

    // New rise on bit 0 lands on the same edge as a W1C of bit 0.
    PortIn = 8'h04;
    next_cycle(); next_cycle(); next_cycle();
    PortIn = 8'h05;                    // before edge b
    next_cycle();                      // edge b
    next_cycle();                      // edge b+1: rise[0] now high
    drive(BASE + 32'h8, 32'h1, 1'b1, 1'b1);
    #1 check("edge_pre_collide", bus.ReadData, 32'h4);
    next_cycle();                      // edge b+2: set and clear together
    drive(BASE + 32'h8, 32'h0, 1'b0, 1'b1);
    #1 check("edge_set_wins", bus.ReadData, 32'h5);

    // Counter load and wrap.
    drive(BASE + 32'hC, 32'hFFFF_FFFE, 1'b1, 1'b1);
    next_cycle();
    drive(BASE + 32'hC, 32'h0, 1'b0, 1'b1);
    #1 check("count_load", bus.ReadData, 32'hFFFF_FFFE);
    next_cycle(); #1 check("count_max", bus.ReadData, 32'hFFFF_FFFF);
    next_cycle(); #1 check("count_wrap", bus.ReadData, 32'h0);

    // Asynchronous reset mid-cycle while a PORT_OUT store is pending.
    PortIn = 8'h00;
    next_cycle();
    drive(BASE, 32'h1111_1111, 1'b1, 1'b1);
    #2 reset = 1'b0;
    #1 check("areset_portout", PortOut, 32'h0);
    check("areset_rd_portout", bus.ReadData, 32'h0);
    bus.Address = BASE + 32'h8;
    #1 check("areset_edge", bus.ReadData, 32'h0);
    bus.Address = BASE + 32'hC;
    #1 check("areset_count", bus.ReadData, 32'h0);
    next_cycle();                      // rising edge passes inside reset
    drive(BASE, 32'h0, 1'b0, 1'b1);
    reset = 1'b1;
    #1 check("areset_no_commit", PortOut, 32'h0);
    check("areset_rd_after", bus.ReadData, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
